// File: rtl/time_keeper_pkg.sv
// Shared definitions for the wall-clock time keeper: BCD field limits,
// FSM state encoding and BCD helper functions.
package time_keeper_pkg;

  localparam int BCD_W = 8;

  localparam logic [BCD_W-1:0] SEC_MAX  = 8'h59;
  localparam logic [BCD_W-1:0] MIN_MAX  = 8'h59;
  localparam logic [BCD_W-1:0] HOUR_MAX = 8'h23;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } state_e;

  // With both digits valid, binary ordering of packed BCD matches decimal ordering.
  function automatic logic bcd_legal(input logic [BCD_W-1:0] v,
                                     input logic [BCD_W-1:0] max);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
  endfunction

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v,
                                               input logic [BCD_W-1:0] max);
    logic [BCD_W-1:0] r;
    if (v == max)            r = '0;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/time_keeper_bcd_mod_counter.sv
// Two-digit BCD modulo counter (0..MAX) with synchronous load; wrap flags the
// MAX->0 transition so stages can be chained.
module time_keeper_bcd_mod_counter
  import time_keeper_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = SEC_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] val,
  output logic             wrap
);

  logic [BCD_W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load)     val_d = load_val;
    else if (inc) val_d = bcd_inc(val_q, MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) val_q <= '0;
    else        val_q <= val_d;
  end

  assign val  = val_q;
  assign wrap = inc & (val_q == MAX);

endmodule

// File: rtl/time_keeper.sv
// 24 h BCD wall clock driven by the rising edges of a 1 Hz tick, with a
// prescaler, a valid/ready time load and seconds/minutes/hours/day carry pulses.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             run_en,
  input  logic             set_valid,
  output logic             set_ready,
  input  logic [BCD_W-1:0] set_hh,
  input  logic [BCD_W-1:0] set_mm,
  input  logic [BCD_W-1:0] set_ss,
  output logic             set_err,
  output logic [BCD_W-1:0] hh,
  output logic [BCD_W-1:0] mm,
  output logic [BCD_W-1:0] ss,
  output logic             sec_p,
  output logic             min_p,
  output logic             hour_p,
  output logic             day_p
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  state_e          state_q;
  logic            tick_d_q, tick_d_d;
  logic [PW-1:0]   pre_cnt_q, pre_cnt_d;
  logic            sec_p_q, sec_p_d;
  logic            min_p_q, min_p_d;
  logic            hour_p_q, hour_p_d;
  logic            day_p_q, day_p_d;
  logic            set_err_q, set_err_d;

  logic adv, sec_adv, accept, legal, load_ok, count_en;
  logic ss_wrap, mm_wrap, hh_wrap;

  assign set_ready = (state_q == S_RUN) & reset;
  assign accept    = set_valid & set_ready;
  assign legal     = bcd_legal(set_ss, SEC_MAX) & bcd_legal(set_mm, MIN_MAX)
                   & bcd_legal(set_hh, HOUR_MAX);
  assign load_ok   = accept & legal;

  // Edges seen while run_en is low are dropped, not queued.
  assign adv     = tick_in & ~tick_d_q & run_en;
  assign sec_adv = adv & (pre_cnt_q == PRE_LAST);
  // A load accepted on the same edge as a second takes priority; that second is lost.
  assign count_en = sec_adv & ~accept;

  always_comb begin
    tick_d_d  = tick_in;
    pre_cnt_d = pre_cnt_q;
    if (load_ok)      pre_cnt_d = '0;
    else if (adv)     pre_cnt_d = sec_adv ? '0 : pre_cnt_q + PW'(1);
    sec_p_d   = count_en;
    min_p_d   = ss_wrap;
    hour_p_d  = mm_wrap;
    day_p_d   = hh_wrap;
    set_err_d = accept & ~legal;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_RUN;
      tick_d_q  <= 1'b0;
      pre_cnt_q <= '0;
      sec_p_q   <= 1'b0;
      min_p_q   <= 1'b0;
      hour_p_q  <= 1'b0;
      day_p_q   <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN:   if (accept) state_q <= S_LOAD;
        S_LOAD:  state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
      tick_d_q  <= tick_d_d;
      pre_cnt_q <= pre_cnt_d;
      sec_p_q   <= sec_p_d;
      min_p_q   <= min_p_d;
      hour_p_q  <= hour_p_d;
      day_p_q   <= day_p_d;
      set_err_q <= set_err_d;
    end
  end

  time_keeper_bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
    .clk      (clk),
    .reset    (reset),
    .inc      (count_en),
    .load     (load_ok),
    .load_val (set_ss),
    .val      (ss),
    .wrap     (ss_wrap)
  );

  time_keeper_bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
    .clk      (clk),
    .reset    (reset),
    .inc      (ss_wrap),
    .load     (load_ok),
    .load_val (set_mm),
    .val      (mm),
    .wrap     (mm_wrap)
  );

  time_keeper_bcd_mod_counter #(.MAX(HOUR_MAX)) u_hh (
    .clk      (clk),
    .reset    (reset),
    .inc      (mm_wrap),
    .load     (load_ok),
    .load_val (set_hh),
    .val      (hh),
    .wrap     (hh_wrap)
  );

  assign sec_p   = sec_p_q;
  assign min_p   = min_p_q;
  assign hour_p  = hour_p_q;
  assign day_p   = day_p_q;
  assign set_err = set_err_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: a PRESCALE=1 and a PRESCALE=4 instance share
// all inputs; vectors and corner sequences check time, pulses and the load handshake.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       reset, tick_in, run_en, set_valid;
  logic [7:0] set_hh, set_mm, set_ss;

  logic       r1, e1, sp1, mp1, hp1, dp1;
  logic [7:0] hh1, mm1, ss1;
  logic       r4, e4, sp4, mp4, hp4, dp4;
  logic [7:0] hh4, mm4, ss4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  time_keeper #(.PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .run_en(run_en),
    .set_valid(set_valid), .set_ready(r1), .set_hh(set_hh), .set_mm(set_mm),
    .set_ss(set_ss), .set_err(e1), .hh(hh1), .mm(mm1), .ss(ss1),
    .sec_p(sp1), .min_p(mp1), .hour_p(hp1), .day_p(dp1)
  );

  time_keeper #(.PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .run_en(run_en),
    .set_valid(set_valid), .set_ready(r4), .set_hh(set_hh), .set_mm(set_mm),
    .set_ss(set_ss), .set_err(e4), .hh(hh4), .mm(mm4), .ss(ss4),
    .sec_p(sp4), .min_p(mp4), .hour_p(hp4), .day_p(dp4)
  );

  typedef struct {
    logic [7:0] h, m, s;
    int         n;
    logic [7:0] eh, em, es;
    logic       ee;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_hi();
    tick_in = 1'b1;
    step();
  endtask

  task automatic edge_lo();
    tick_in = 1'b0;
    step();
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      edge_hi();
      edge_lo();
    end
  endtask

  // Accept happens on the first edge; set_err is already registered after it.
  task automatic do_load(input logic [7:0] h, input logic [7:0] m,
                         input logic [7:0] s, output logic err);
    set_hh = h; set_mm = m; set_ss = s;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    err = e1;
    step();
  endtask

  initial begin
    logic err;
    int   cnt;

    tbl[0] = '{8'h09, 8'h05, 8'h07, 0, 8'h09, 8'h05, 8'h07, 1'b0};
    tbl[1] = '{8'h12, 8'h34, 8'h60, 0, 8'h09, 8'h05, 8'h07, 1'b1};
    tbl[2] = '{8'h1A, 8'h00, 8'h00, 0, 8'h09, 8'h05, 8'h07, 1'b1};
    tbl[3] = '{8'h09, 8'h05, 8'h07, 3, 8'h09, 8'h05, 8'h10, 1'b0};
    tbl[4] = '{8'h19, 8'h59, 8'h59, 1, 8'h20, 8'h00, 8'h00, 1'b0};
    tbl[5] = '{8'h23, 8'h5A, 8'h00, 0, 8'h20, 8'h00, 8'h00, 1'b1};
    tbl[6] = '{8'h24, 8'h00, 8'h00, 0, 8'h20, 8'h00, 8'h00, 1'b1};
    tbl[7] = '{8'h00, 8'h09, 8'h59, 1, 8'h00, 8'h10, 8'h00, 1'b0};
    tbl[8] = '{8'h13, 8'h45, 8'h29, 2, 8'h13, 8'h45, 8'h31, 1'b0};

    reset = 1'b0; tick_in = 1'b0; run_en = 1'b1; set_valid = 1'b0;
    set_hh = '0; set_mm = '0; set_ss = '0;

    // Reset held with the tick toggling.
    for (int i = 0; i < 3; i++) begin
      tick_in = ~tick_in;
      set_valid = 1'b1;
      step();
      chk("rst_time",   {hh1, mm1, ss1}, 24'h000000);
      chk("rst_ready",  {r1, r4}, 2'b00);
      chk("rst_pulses", {sp1, mp1, hp1, dp1, e1}, 5'b0);
    end
    set_valid = 1'b0;
    reset = 1'b1;
    tick_in = 1'b0;
    #1;
    chk("rel_ready", {r1, r4}, 2'b11);
    step();
    chk("rel_time", {hh1, mm1, ss1}, 24'h000000);

    // Day rollover.
    do_load(8'h23, 8'h59, 8'h58, err);
    chk("roll_load_err", err, 1'b0);
    edge_hi();
    chk("roll_t1", {hh1, mm1, ss1}, 24'h235959);
    chk("roll_p1", {sp1, mp1, hp1, dp1}, 4'b1000);
    edge_lo();
    chk("roll_p1_clr", {sp1, mp1, hp1, dp1}, 4'b0000);
    edge_hi();
    chk("roll_t2", {hh1, mm1, ss1}, 24'h000000);
    chk("roll_p2", {sp1, mp1, hp1, dp1}, 4'b1111);
    edge_lo();
    chk("roll_p2_clr", {sp1, mp1, hp1, dp1}, 4'b0000);

    // Table of loads followed by counted edges.
    for (int i = 0; i < 9; i++) begin
      do_load(tbl[i].h, tbl[i].m, tbl[i].s, err);
      chk($sformatf("vec%0d_err", i), err, tbl[i].ee);
      chk($sformatf("vec%0d_err_clr", i), e1, 1'b0);
      edges(tbl[i].n);
      chk($sformatf("vec%0d_time", i), {hh1, mm1, ss1}, {tbl[i].eh, tbl[i].em, tbl[i].es});
    end

    // Load coincident with a tick rising edge: the load wins.
    set_hh = 8'h07; set_mm = 8'h15; set_ss = 8'h30;
    set_valid = 1'b1;
    tick_in = 1'b1;
    step();
    chk("coin_time",  {hh1, mm1, ss1}, 24'h071530);
    chk("coin_pulse", {sp1, mp1, hp1, dp1}, 4'b0000);
    set_valid = 1'b0;
    tick_in = 1'b0;
    step();
    edge_hi();
    chk("coin_next", {hh1, mm1, ss1}, 24'h071531);
    chk("coin_secp", sp1, 1'b1);
    edge_lo();

    // Prescaler and run_en on the PRESCALE=4 instance.
    do_load(8'h00, 8'h00, 8'h00, err);
    run_en = 1'b0;
    edges(2);
    chk("runen_ss1", ss1, 8'h00);
    chk("runen_ss4", ss4, 8'h00);
    run_en = 1'b1;
    edges(3);
    chk("pre_3edges", ss4, 8'h00);
    edge_hi();
    chk("pre_4edges", ss4, 8'h01);
    chk("pre_secp",   sp4, 1'b1);
    edge_lo();
    edges(2);
    reset = 1'b0;
    step();
    chk("midrst_ready", r4, 1'b0);
    reset = 1'b1;
    step();
    chk("midrst_time", {hh4, mm4, ss4}, 24'h000000);
    edges(3);
    chk("midrst_3edges", ss4, 8'h00);
    edge_hi();
    chk("midrst_4edges", ss4, 8'h01);
    edge_lo();

    // Tick held high counts once.
    do_load(8'h10, 8'h00, 8'h00, err);
    tick_in = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      cnt += int'(sp1);
    end
    tick_in = 1'b0;
    step();
    chk("hold_count", cnt, 1);
    chk("hold_ss",    ss1, 8'h01);

    // set_valid held high: ready alternates, two accepts.
    set_hh = 8'h11; set_mm = 8'h22; set_ss = 8'h33;
    set_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold_ready%0d", i), r1, (i % 2 == 0) ? 1'b1 : 1'b0);
      cnt += int'(r1);
      step();
    end
    set_valid = 1'b0;
    chk("hold_accepts", cnt, 2);
    chk("hold_time", {hh1, mm1, ss1}, 24'h112233);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
